sticky_event_bank: RTL and testbench

- Parametrised, multi-channel successor of the single-bit sticky flag (async clear, synchronous set-on-input).
- Each channel detects a configurable event (level, rising, falling or either edge) on its input and latches it into a sticky status bit. The bit stays set until software clears it with write-1-to-clear.
- Also per channel: a saturating occurrence counter and a sticky overflow bit. All channels feed one masked, registered interrupt.
- Sits between raw event sources and the CPU interrupt/status register file.

---
 rtl/seb_pkg.sv | 25 ++
 rtl/seb_channel.sv | 92 +++++++++
 rtl/sticky_event_bank.sv | 67 ++++++
 tb/tb_sticky_event_bank.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/seb_pkg.sv
// Shared types and helpers for the sticky event bank.
// Detect modes are encoded per channel as a 2-bit field of the mode bus.
package seb_pkg;

    typedef enum logic [1:0] {
        SEB_LEVEL = 2'b00,
        SEB_RISE  = 2'b01,
        SEB_FALL  = 2'b10,
        SEB_BOTH  = 2'b11
    } seb_mode_e;

    // Event detect: current sample against previous sample under the given mode.
    function automatic logic seb_hit(input logic [1:0] mode, input logic cur, input logic prev);
        logic hit;
        case (seb_mode_e'(mode))
            SEB_LEVEL: hit = cur;
            SEB_RISE:  hit = cur & ~prev;
            SEB_FALL:  hit = ~cur & prev;
            SEB_BOTH:  hit = cur ^ prev;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/seb_channel.sv
// One event channel: optional input synchroniser, previous-sample register,
// edge/level detect, sticky status, sticky overflow and saturating counter.
// Build option: SEB_SYNC_EN adds a 2-flop synchroniser in front of detection.
module seb_channel
    import seb_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             evt_in,
    input  logic [1:0]       mode,
    input  logic             clr,
    output logic             status,
    output logic             status_next,
    output logic             overflow,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             evt_s;
    logic             evt_d_r;
    logic             hit_s;
    logic             status_r;
    logic             status_next_s;
    logic             overflow_r;
    logic [CNT_W-1:0] cnt_r;

`ifdef SEB_SYNC_EN
    logic [1:0] sync_r;

    // Two-flop synchroniser so evt_in may come from another clock domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], evt_in};
        end
    end

    assign evt_s = sync_r[1];
`else
    assign evt_s = evt_in;
`endif

    assign hit_s         = seb_hit(mode, evt_s, evt_d_r);
    // A hit in the same cycle as a clear wins, so no event is ever dropped.
    assign status_next_s = hit_s | (status_r & ~clr);

    // Sample history, sticky flags and saturating occurrence counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt_d_r    <= 1'b0;
            status_r   <= 1'b0;
            overflow_r <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
        end else begin
            evt_d_r  <= evt_s;
            status_r <= status_next_s;

            if (clr) begin
                overflow_r <= 1'b0;
            end else if (hit_s && status_r) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end

            if (hit_s) begin
                if (clr) begin
                    cnt_r <= CNT_ONE;
                end else if (cnt_r != CNT_MAX) begin
                    cnt_r <= cnt_r + CNT_ONE;
                end else begin
                    cnt_r <= cnt_r;
                end
            end else if (clr) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign status      = status_r;
    assign status_next = status_next_s;
    assign overflow    = overflow_r;
    assign cnt         = cnt_r;

endmodule

// File: rtl/sticky_event_bank.sv
// Multi-channel sticky event bank: WIDTH detect channels with W1C status,
// overflow and counters, a counter read mux and one masked registered irq.
// Build option: SEB_SYNC_EN enables per-channel input synchronisers.
module sticky_event_bank
    import seb_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int CNT_W = 4,
    localparam int SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   evt_in,
    input  logic [2*WIDTH-1:0] mode,
    input  logic               clr_we,
    input  logic [WIDTH-1:0]   clr_mask,
    input  logic [WIDTH-1:0]   irq_mask,
    input  logic [SEL_W-1:0]   cnt_sel,
    output logic [WIDTH-1:0]   status,
    output logic [WIDTH-1:0]   overflow,
    output logic [CNT_W-1:0]   cnt_out,
    output logic               irq
);

    logic [WIDTH-1:0] clr_s;
    logic [WIDTH-1:0] status_next_s;
    logic [CNT_W-1:0] cnt_arr_s [WIDTH];
    logic             irq_r;

    assign clr_s = clr_mask & {WIDTH{clr_we}};

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        seb_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .evt_in     (evt_in[i]),
            .mode       (mode[2*i +: 2]),
            .clr        (clr_s[i]),
            .status     (status[i]),
            .status_next(status_next_s[i]),
            .overflow   (overflow[i]),
            .cnt        (cnt_arr_s[i])
        );
    end

    // Counter read mux; a selector beyond the last channel reads as zero.
    always_comb begin
        cnt_out = {CNT_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            cnt_out = cnt_out | ((cnt_sel == SEL_W'(i)) ? cnt_arr_s[i] : {CNT_W{1'b0}});
        end
    end

    // Interrupt built from next-state status so it rises with status itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |(status_next_s & irq_mask);
        end
    end

    assign irq = irq_r;

endmodule

// File: tb/tb_sticky_event_bank.sv
// Directed self-checking bench for sticky_event_bank (WIDTH=8, CNT_W=4).
// Input-to-status latency follows the SEB_SYNC_EN build option.
module tb_sticky_event_bank;

`ifdef SEB_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  evt_in;
    logic [15:0] mode;
    logic        clr_we;
    logic [7:0]  clr_mask;
    logic [7:0]  irq_mask;
    logic [2:0]  cnt_sel;
    logic [7:0]  status;
    logic [7:0]  overflow;
    logic [3:0]  cnt_out;
    logic        irq;

    int total = 0;
    int bad   = 0;

    sticky_event_bank #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .evt_in(evt_in), .mode(mode),
        .clr_we(clr_we), .clr_mask(clr_mask), .irq_mask(irq_mask),
        .cnt_sel(cnt_sel), .status(status), .overflow(overflow),
        .cnt_out(cnt_out), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear(input logic [7:0] m);
        clr_we   = 1'b1;
        clr_mask = m;
        tick(1);
        clr_we   = 1'b0;
        clr_mask = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b0; evt_in = 8'hFF; mode = 16'h5555;
        clr_we = 1'b0; clr_mask = 8'h00; irq_mask = 8'h00; cnt_sel = 3'd0;
        tick(2);
        total++; if (status !== 8'h00) begin bad++; $display("FAIL rst_status got=%h exp=%h", status, 8'h00); end
        total++; if (cnt_out !== 4'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=%0d", cnt_out, 0); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=%b", irq, 1'b0); end
        rst = 1'b1;
        tick(LAT);
        total++; if (status !== 8'hFF) begin bad++; $display("FAIL rel_status got=%h exp=%h", status, 8'hFF); end
        total++; if (cnt_out !== 4'd1) begin bad++; $display("FAIL rel_cnt0 got=%0d exp=%0d", cnt_out, 1); end
        cnt_sel = 3'd5; #1;
        total++; if (cnt_out !== 4'd1) begin bad++; $display("FAIL rel_cnt5 got=%0d exp=%0d", cnt_out, 1); end
        tick(1);
        total++; if (cnt_out !== 4'd1) begin bad++; $display("FAIL idle_cnt5 got=%0d exp=%0d", cnt_out, 1); end
        total++; if (overflow !== 8'h00) begin bad++; $display("FAIL idle_ovf got=%h exp=%h", overflow, 8'h00); end
        evt_in = 8'h00;
        tick(4);
        clear(8'hFF);
        total++; if (status !== 8'h00) begin bad++; $display("FAIL clr_all_status got=%h exp=%h", status, 8'h00); end
        total++; if (cnt_out !== 4'd0) begin bad++; $display("FAIL clr_all_cnt got=%0d exp=%0d", cnt_out, 0); end
    endtask

    task automatic test_rise();
        irq_mask = 8'h01; cnt_sel = 3'd0;
        evt_in[0] = 1'b1;
        tick(LAT);
        total++; if (status !== 8'h01) begin bad++; $display("FAIL rise_status got=%h exp=%h", status, 8'h01); end
        total++; if (cnt_out !== 4'd1) begin bad++; $display("FAIL rise_cnt got=%0d exp=%0d", cnt_out, 1); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL rise_irq got=%b exp=%b", irq, 1'b1); end
        tick(2);
        evt_in[0] = 1'b0;
        tick(4);
        total++; if (cnt_out !== 4'd1) begin bad++; $display("FAIL rise_cnt_hold got=%0d exp=%0d", cnt_out, 1); end
        total++; if (overflow !== 8'h00) begin bad++; $display("FAIL rise_ovf got=%h exp=%h", overflow, 8'h00); end
        irq_mask = 8'h00;
        tick(1);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL rise_irq_masked got=%b exp=%b", irq, 1'b0); end
        clear(8'h01);
        total++; if (status !== 8'h00) begin bad++; $display("FAIL rise_clr got=%h exp=%h", status, 8'h00); end
    endtask

    task automatic test_both_w1c();
        mode = 16'h55D5; irq_mask = 8'h08; cnt_sel = 3'd3;
        evt_in[3] = 1'b1;
        tick(LAT);
        total++; if (status !== 8'h08) begin bad++; $display("FAIL both_status got=%h exp=%h", status, 8'h08); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL both_irq got=%b exp=%b", irq, 1'b1); end
        evt_in[3] = 1'b0;
        tick(LAT - 1);
        clear(8'h08);
        total++; if (status !== 8'h08) begin bad++; $display("FAIL race_status got=%h exp=%h", status, 8'h08); end
        total++; if (cnt_out !== 4'd1) begin bad++; $display("FAIL race_cnt got=%0d exp=%0d", cnt_out, 1); end
        total++; if (overflow !== 8'h00) begin bad++; $display("FAIL race_ovf got=%h exp=%h", overflow, 8'h00); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL race_irq got=%b exp=%b", irq, 1'b1); end
        tick(2);
        clear(8'h08);
        total++; if (status !== 8'h00) begin bad++; $display("FAIL w1c_status got=%h exp=%h", status, 8'h00); end
        total++; if (cnt_out !== 4'd0) begin bad++; $display("FAIL w1c_cnt got=%0d exp=%0d", cnt_out, 0); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL w1c_irq got=%b exp=%b", irq, 1'b0); end
    endtask

    task automatic test_saturation();
        mode = 16'h5551; irq_mask = 8'h00; cnt_sel = 3'd1;
        evt_in[1] = 1'b1;
        tick(LAT);
        total++; if (cnt_out !== 4'd1) begin bad++; $display("FAIL sat_cnt1 got=%0d exp=%0d", cnt_out, 1); end
        total++; if (overflow !== 8'h00) begin bad++; $display("FAIL sat_ovf1 got=%h exp=%h", overflow, 8'h00); end
        tick(1);
        total++; if (cnt_out !== 4'd2) begin bad++; $display("FAIL sat_cnt2 got=%0d exp=%0d", cnt_out, 2); end
        total++; if (overflow !== 8'h02) begin bad++; $display("FAIL sat_ovf2 got=%h exp=%h", overflow, 8'h02); end
        tick(18);
        total++; if (cnt_out !== 4'd15) begin bad++; $display("FAIL sat_cnt_max got=%0d exp=%0d", cnt_out, 15); end
        evt_in[1] = 1'b0;
        tick(4);
        total++; if (cnt_out !== 4'd15) begin bad++; $display("FAIL sat_cnt_hold got=%0d exp=%0d", cnt_out, 15); end
        clear(8'h02);
        total++; if (cnt_out !== 4'd0) begin bad++; $display("FAIL sat_clr_cnt got=%0d exp=%0d", cnt_out, 0); end
        total++; if (overflow !== 8'h00) begin bad++; $display("FAIL sat_clr_ovf got=%h exp=%h", overflow, 8'h00); end
        total++; if (status !== 8'h00) begin bad++; $display("FAIL sat_clr_status got=%h exp=%h", status, 8'h00); end
    endtask

    task automatic test_fall_mask();
        mode = 16'h9555; irq_mask = 8'h00; cnt_sel = 3'd7;
        evt_in[7] = 1'b1;
        tick(4);
        total++; if (status !== 8'h00) begin bad++; $display("FAIL fall_norise got=%h exp=%h", status, 8'h00); end
        evt_in[7] = 1'b0;
        tick(LAT);
        total++; if (status !== 8'h80) begin bad++; $display("FAIL fall_status got=%h exp=%h", status, 8'h80); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL fall_irq_off got=%b exp=%b", irq, 1'b0); end
        irq_mask = 8'h80; #1;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL unmask_lag got=%b exp=%b", irq, 1'b0); end
        tick(1);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL unmask_irq got=%b exp=%b", irq, 1'b1); end
        irq_mask = 8'h00; #1;
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL mask_lag got=%b exp=%b", irq, 1'b1); end
        tick(1);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL mask_irq got=%b exp=%b", irq, 1'b0); end
        irq_mask = 8'h80;
        tick(1);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL remask_irq got=%b exp=%b", irq, 1'b1); end
    endtask

    task automatic test_async_reset();
        #2;
        rst = 1'b0;
        #1;
        total++; if (status !== 8'h00) begin bad++; $display("FAIL arst_status got=%h exp=%h", status, 8'h00); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL arst_irq got=%b exp=%b", irq, 1'b0); end
        total++; if (cnt_out !== 4'd0) begin bad++; $display("FAIL arst_cnt got=%0d exp=%0d", cnt_out, 0); end
        #1;
        rst = 1'b1;
        tick(4);
        total++; if (status !== 8'h00) begin bad++; $display("FAIL post_arst_status got=%h exp=%h", status, 8'h00); end
    endtask

    initial begin
        test_reset();
        test_rise();
        test_both_w1c();
        test_saturation();
        test_fall_mask();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
